// File: rtl/mem_arbiter_if.sv
// Requester/memory bus of the two-port data-memory arbiter.
// Handshake: a requester holds reqN_i (with wrN_i/adrN_i/dataN_i stable) until it sees ackN_o; ackN_o is a one-cycle completion pulse and rdata_o is valid only while that ack is high.
interface mem_arbiter_if;
   logic        req0_i;
   logic        req1_i;
   logic        wr0_i;
   logic        wr1_i;
   logic [31:0] adr0_i;
   logic [31:0] adr1_i;
   logic [31:0] data0_i;
   logic [31:0] data1_i;
   logic        gnt0_o;
   logic        gnt1_o;
   logic        ack0_o;
   logic        ack1_o;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic [31:0] mem_adr_o;
   logic [31:0] mem_data_o;
   logic        mem_wr_o;
   logic        mem_re_o;
   logic [31:0] mem_data_i;

   modport slave (
      input  req0_i, req1_i, wr0_i, wr1_i, adr0_i, adr1_i, data0_i, data1_i,
      input  mem_data_i,
      output gnt0_o, gnt1_o, ack0_o, ack1_o, rdata_o, stall_o,
      output mem_adr_o, mem_data_o, mem_wr_o, mem_re_o
   );

   modport master (
      output req0_i, req1_i, wr0_i, wr1_i, adr0_i, adr1_i, data0_i, data1_i,
      output mem_data_i,
      input  gnt0_o, gnt1_o, ack0_o, ack1_o, rdata_o, stall_o,
      input  mem_adr_o, mem_data_o, mem_wr_o, mem_re_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS (LAT cycles) -> DONE, round-robin on ties.
// Define MEM_ARB_FIXED_PRIO_EN to make requester 0 always win ties (no last-grant register).
module mem_arbiter #(
   parameter int unsigned LAT = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   mem_arbiter_if.slave bus,
   output logic [1:0]   dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        owner;
   logic        wr_q;
   logic        pick;
   logic        pick_wr;
   logic [31:0] pick_adr;
   logic [31:0] pick_data;

`ifdef MEM_ARB_FIXED_PRIO_EN
   always_comb begin
      pick = bus.req0_i ? 1'b0 : 1'b1;
   end
`else
   logic last_gnt;

   // On a tie the requester that was not served last wins.
   always_comb begin
      if (bus.req0_i && bus.req1_i) pick = ~last_gnt;
      else                          pick = bus.req0_i ? 1'b0 : 1'b1;
   end
`endif

   always_comb begin
      pick_wr   = pick ? bus.wr1_i   : bus.wr0_i;
      pick_adr  = pick ? bus.adr1_i  : bus.adr0_i;
      pick_data = pick ? bus.data1_i : bus.data0_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= IDLE;
         cnt            <= '0;
         owner          <= 1'b0;
         wr_q           <= 1'b0;
         bus.gnt0_o     <= 1'b0;
         bus.gnt1_o     <= 1'b0;
         bus.ack0_o     <= 1'b0;
         bus.ack1_o     <= 1'b0;
         bus.rdata_o    <= '0;
         bus.mem_adr_o  <= '0;
         bus.mem_data_o <= '0;
         bus.mem_wr_o   <= 1'b0;
         bus.mem_re_o   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_gnt       <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0_i || bus.req1_i) begin
                  owner          <= pick;
                  wr_q           <= pick_wr;
                  bus.mem_adr_o  <= pick_adr;
                  bus.mem_data_o <= pick_data;
                  bus.gnt0_o     <= ~pick;
                  bus.gnt1_o     <= pick;
                  bus.mem_wr_o   <= pick_wr;
                  bus.mem_re_o   <= ~pick_wr;
                  cnt            <= CNT_INIT;
`ifndef MEM_ARB_FIXED_PRIO_EN
                  last_gnt       <= pick;
`endif
                  state          <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  // Memory data is sampled on the last strobe cycle.
                  if (!wr_q) bus.rdata_o <= bus.mem_data_i;
                  bus.mem_wr_o <= 1'b0;
                  bus.mem_re_o <= 1'b0;
                  bus.ack0_o   <= ~owner;
                  bus.ack1_o   <= owner;
                  state        <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               bus.ack0_o <= 1'b0;
               bus.ack1_o <= 1'b0;
               bus.gnt0_o <= 1'b0;
               bus.gnt1_o <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stall_o  = bus.req0_i & ~bus.ack0_o;
   assign dbg_state_o  = state;

   a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      !(bus.gnt0_o && bus.gnt1_o));
   a_ack_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      !(bus.ack0_o && bus.ack1_o));
   a_strobe_in_access: assert property (@(posedge clk_i) disable iff (rst_i)
      (state != ACCESS) |-> !(bus.mem_wr_o || bus.mem_re_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: LAT=2 instance for the main scenarios, LAT=1 instance for the short-latency read.
module tb_mem_arbiter;
   localparam int LAT0 = 2;
   localparam int LAT1 = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state0;
   logic [1:0] state1;

   mem_arbiter_if bus0 ();
   mem_arbiter_if bus1 ();

   mem_arbiter #(.LAT(LAT0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .bus(bus0.slave), .dbg_state_o(state0)
   );
   mem_arbiter #(.LAT(LAT1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .bus(bus1.slave), .dbg_state_o(state1)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [32:0] exp_q[$];
   logic [31:0] mem0 [0:63];
   logic [31:0] mem1 [0:63];
   logic [31:0] ref_mem [0:63];
   logic [31:0] last_rdata;
   logic        last_served;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      last_rdata  = '0;
      last_served = 1'b1;
   endtask

   // ---------------- memory models ----------------
   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      return 32'hC0DE0000 + 32'(i * 17);
   endfunction

   initial begin : mem_model
      for (int i = 0; i < 64; i++) begin
         mem0[i] = init_word(i);
         mem1[i] = init_word(i);
      end
      forever begin
         @(posedge clk);
         if (bus0.mem_wr_o) mem0[bus0.mem_adr_o[7:2]] <= bus0.mem_data_o;
         if (bus1.mem_wr_o) mem1[bus1.mem_adr_o[7:2]] <= bus1.mem_data_o;
      end
   end

   assign bus0.mem_data_i = mem0[bus0.mem_adr_o[7:2]];
   assign bus1.mem_data_i = mem1[bus1.mem_adr_o[7:2]];

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus0.req0_i = 0; bus0.req1_i = 0; bus0.wr0_i = 0; bus0.wr1_i = 0;
      bus0.adr0_i = '0; bus0.adr1_i = '0; bus0.data0_i = '0; bus0.data1_i = '0;
      bus1.req0_i = 0; bus1.req1_i = 0; bus1.wr0_i = 0; bus1.wr1_i = 0;
      bus1.adr0_i = '0; bus1.adr1_i = '0; bus1.data0_i = '0; bus1.data1_i = '0;
   endtask

   task automatic drive_req(input bit who, input bit wr, input logic [31:0] adr, input logic [31:0] data);
      if (!who) begin
         bus0.req0_i = 1'b1; bus0.wr0_i = wr; bus0.adr0_i = adr; bus0.data0_i = data;
      end else begin
         bus0.req1_i = 1'b1; bus0.wr1_i = wr; bus0.adr1_i = adr; bus0.data1_i = data;
      end
   endtask

   task automatic drop_req(input bit who);
      if (!who) bus0.req0_i = 1'b0;
      else      bus0.req1_i = 1'b0;
   endtask

   // One access on bus0; cycle k = number of clock edges after the request was raised.
   task automatic do_access(input bit who, input bit wr, input logic [31:0] adr, input logic [31:0] data,
                            output logic [31:0] rd, output int ack_cyc, output int wr_cyc,
                            output int re_cyc, output bit stall_bad);
      bit got;
      got = 0; ack_cyc = -1; wr_cyc = 0; re_cyc = 0; stall_bad = 0; rd = '0;
      @(negedge clk);
      drive_req(who, wr, adr, data);
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clk);
         if (bus0.mem_wr_o) wr_cyc++;
         if (bus0.mem_re_o) re_cyc++;
         if (who ? bus0.ack1_o : bus0.ack0_o) begin
            got = 1; ack_cyc = k; rd = bus0.rdata_o;
         end
         if (!who && (bus0.stall_o !== !got)) stall_bad = 1;
      end
      drop_req(who);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({bus0.gnt0_o, bus0.gnt1_o, bus0.ack0_o, bus0.ack1_o, bus0.mem_wr_o, bus0.mem_re_o} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 000000", {bus0.gnt0_o, bus0.gnt1_o, bus0.ack0_o, bus0.ack1_o, bus0.mem_wr_o, bus0.mem_re_o});
      end
      n_checks++;
      if (bus0.rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", bus0.rdata_o); end
      n_checks++;
      if ({bus0.mem_adr_o, bus0.mem_data_o} !== 64'h0) begin
         n_fail++; $display("FAIL reset_mem_bus: got %h/%h required 0/0", bus0.mem_adr_o, bus0.mem_data_o);
      end
      n_checks++;
      if (state0 !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", state0); end
      n_checks++;
      if (bus0.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", bus0.stall_o); end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus0.gnt0_o, bus0.gnt1_o, bus1.gnt0_o, bus1.gnt1_o} !== 4'b0) begin
         n_fail++; $display("FAIL idle_no_grant: got %b required 0000", {bus0.gnt0_o, bus0.gnt1_o, bus1.gnt0_o, bus1.gnt1_o});
      end
   endtask

   task automatic test_single_read();
      logic [31:0] rd; int ac, wc, rc; bit sb;
      do_access(1'b0, 1'b0, 32'h10, 32'h0, rd, ac, wc, rc, sb);
      n_checks++;
      if (ac !== LAT0 + 1) begin n_fail++; $display("FAIL read_ack_cycle: got %0d required %0d", ac, LAT0 + 1); end
      n_checks++;
      if (rc !== LAT0) begin n_fail++; $display("FAIL read_re_cycles: got %0d required %0d", rc, LAT0); end
      n_checks++;
      if (wc !== 0) begin n_fail++; $display("FAIL read_wr_cycles: got %0d required 0", wc); end
      n_checks++;
      if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h required deadbeef", rd); end
      n_checks++;
      if (sb !== 1'b0) begin n_fail++; $display("FAIL read_stall: stall differed from req0 & ~ack0"); end
      last_rdata = ref_mem[4];
   endtask

   task automatic test_write_read();
      logic [31:0] rd; int ac, wc, rc; bit sb;
      do_access(1'b1, 1'b1, 32'h04, 32'h12345678, rd, ac, wc, rc, sb);
      ref_mem[1] = 32'h12345678;
      n_checks++;
      if (wc !== LAT0) begin n_fail++; $display("FAIL write_wr_cycles: got %0d required %0d", wc, LAT0); end
      n_checks++;
      if (rc !== 0) begin n_fail++; $display("FAIL write_re_cycles: got %0d required 0", rc); end
      n_checks++;
      if (ac !== LAT0 + 1) begin n_fail++; $display("FAIL write_ack_cycle: got %0d required %0d", ac, LAT0 + 1); end
      n_checks++;
      if (rd !== last_rdata) begin n_fail++; $display("FAIL write_rdata_held: got %h required %h", rd, last_rdata); end
      do_access(1'b1, 1'b0, 32'h04, 32'h0, rd, ac, wc, rc, sb);
      n_checks++;
      if (rd !== ref_mem[1]) begin n_fail++; $display("FAIL write_readback: got %h required %h", rd, ref_mem[1]); end
      n_checks++;
      if (ac !== LAT0 + 1) begin n_fail++; $display("FAIL readback_ack_cycle: got %0d required %0d", ac, LAT0 + 1); end
      last_rdata = ref_mem[1];
   endtask

   task automatic test_drop_mid_access();
      int acks; int ack_k; logic [31:0] rd;
      acks = 0; ack_k = -1; rd = '0;
      @(negedge clk);
      drive_req(1'b0, 1'b0, 32'h0C, 32'h0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) begin
            n_checks++;
            if (bus0.gnt0_o !== 1'b1) begin n_fail++; $display("FAIL drop_grant: got %b required 1", bus0.gnt0_o); end
            drop_req(1'b0);
         end
         if (bus0.ack0_o) begin acks++; ack_k = k; rd = bus0.rdata_o; end
      end
      n_checks++;
      if (acks !== 1) begin n_fail++; $display("FAIL drop_ack_count: got %0d required 1", acks); end
      n_checks++;
      if (ack_k !== LAT0 + 1) begin n_fail++; $display("FAIL drop_ack_cycle: got %0d required %0d", ack_k, LAT0 + 1); end
      n_checks++;
      if (rd !== ref_mem[3]) begin n_fail++; $display("FAIL drop_rdata: got %h required %h", rd, ref_mem[3]); end
      last_rdata = ref_mem[3];
   endtask

   task automatic test_simultaneous();
      logic owners [4]; int cyc [4]; int n_ack; bit excl_bad, data_bad; logic exp_owner;
      apply_reset();
      for (int i = 0; i < 4; i++) begin owners[i] = 1'bx; cyc[i] = -100; end
      n_ack = 0; excl_bad = 0; data_bad = 0;
      drive_req(1'b0, 1'b0, 32'h18, 32'h0);
      drive_req(1'b1, 1'b0, 32'h1C, 32'h0);
      for (int k = 1; k <= 60 && n_ack < 4; k++) begin
         @(negedge clk);
         if ((bus0.gnt0_o && bus0.gnt1_o) || (bus0.ack0_o && bus0.ack1_o)) excl_bad = 1;
         if (bus0.ack0_o || bus0.ack1_o) begin
            owners[n_ack] = bus0.ack1_o;
            cyc[n_ack] = k;
            if (bus0.rdata_o !== ref_mem[bus0.ack1_o ? 7 : 6]) data_bad = 1;
            n_ack++;
         end
      end
      drop_req(1'b0);
      drop_req(1'b1);
      for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         exp_owner = 1'b0;
`else
         exp_owner = 1'(i % 2);
`endif
         n_checks++;
         if (owners[i] !== exp_owner) begin n_fail++; $display("FAIL tie_owner[%0d]: got %b required %b", i, owners[i], exp_owner); end
      end
      n_checks++;
      if (cyc[0] !== LAT0 + 1) begin n_fail++; $display("FAIL tie_first_ack: got %0d required %0d", cyc[0], LAT0 + 1); end
      for (int i = 1; i < 4; i++) begin
         n_checks++;
         if (cyc[i] - cyc[i-1] !== LAT0 + 2) begin
            n_fail++; $display("FAIL tie_ack_spacing[%0d]: got %0d required %0d", i, cyc[i] - cyc[i-1], LAT0 + 2);
         end
      end
      n_checks++;
      if (excl_bad !== 1'b0) begin n_fail++; $display("FAIL tie_exclusive: got overlap required none"); end
      n_checks++;
      if (data_bad !== 1'b0) begin n_fail++; $display("FAIL tie_rdata: got wrong read data required model data"); end
   endtask

   task automatic test_reset_mid_access();
      logic [31:0] rd; int ac, wc, rc; bit sb; int acks_seen; bit got;
      do_access(1'b0, 1'b0, 32'h00, 32'h0, rd, ac, wc, rc, sb);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 32'h14, 32'h0);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus0.mem_re_o, state0} !== 3'b1_01) begin
         n_fail++; $display("FAIL rstmid_in_access: got re=%b state=%0d required re=1 state=1", bus0.mem_re_o, state0);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus0.gnt0_o, bus0.gnt1_o, bus0.ack0_o, bus0.ack1_o, bus0.mem_wr_o, bus0.mem_re_o} !== 6'b0 ||
          {bus0.rdata_o, bus0.mem_adr_o, bus0.mem_data_o} !== 96'h0) begin
         n_fail++; $display("FAIL rstmid_outputs: got ctrl=%b rdata=%h adr=%h data=%h required all 0",
            {bus0.gnt0_o, bus0.gnt1_o, bus0.ack0_o, bus0.ack1_o, bus0.mem_wr_o, bus0.mem_re_o},
            bus0.rdata_o, bus0.mem_adr_o, bus0.mem_data_o);
      end
      n_checks++;
      if (state0 !== 2'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d required 0", state0); end
      drop_req(1'b0);
      acks_seen = 0;
      repeat (3) begin @(negedge clk); if (bus0.ack0_o || bus0.ack1_o) acks_seen++; end
      rst = 1'b0;
      last_rdata = '0; last_served = 1'b1;
      repeat (2) begin @(negedge clk); if (bus0.ack0_o || bus0.ack1_o) acks_seen++; end
      n_checks++;
      if (acks_seen !== 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d acks required 0", acks_seen); end
      drive_req(1'b0, 1'b0, 32'h00, 32'h0);
      drive_req(1'b1, 1'b0, 32'h04, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({bus0.gnt0_o, bus0.gnt1_o} !== 2'b10) begin
         n_fail++; $display("FAIL rstmid_tie_to_0: got gnt0/1=%b required 10", {bus0.gnt0_o, bus0.gnt1_o});
      end
      drop_req(1'b0);
      drop_req(1'b1);
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (bus0.ack0_o) got = 1;
      end
      n_checks++;
      if (got !== 1'b1) begin n_fail++; $display("FAIL rstmid_tie_ack: got no ack0 required ack0"); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      bit wr [2]; logic [31:0] adr [2]; logic [31:0] dat [2];
      logic [1:0] mask, pending; logic first; logic order [2]; int n_ord;
      logic [32:0] e; bit excl_bad;
      apply_reset();
      exp_q.delete();
      excl_bad = 0;
      for (int r = 0; r < 24; r++) begin
         mask = 2'($urandom_range(1, 3));
         for (int j = 0; j < 2; j++) begin
            wr[j]  = 1'($urandom_range(0, 1));
            adr[j] = 32'($urandom_range(0, 7)) << 2;
            dat[j] = $urandom;
         end
         if (mask == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            first = 1'b0;
`else
            first = ~last_served;
`endif
            order[0] = first; order[1] = ~first; n_ord = 2;
         end else begin
            order[0] = (mask == 2'b10); order[1] = 1'b0; n_ord = 1;
         end
         // Reference: serve in arbitration order against the abstract memory image.
         for (int s = 0; s < n_ord; s++) begin
            if (wr[order[s]]) begin
               exp_q.push_back({order[s], last_rdata});
               ref_mem[adr[order[s]][7:2]] = dat[order[s]];
            end else begin
               last_rdata = ref_mem[adr[order[s]][7:2]];
               exp_q.push_back({order[s], last_rdata});
            end
            last_served = order[s];
         end
         for (int j = 0; j < 2; j++)
            if (mask[j]) drive_req(1'(j), wr[j], adr[j], dat[j]);
         pending = mask;
         for (int k = 0; k < 40 && pending != 2'b00; k++) begin
            @(negedge clk);
            if ((bus0.gnt0_o && bus0.gnt1_o) || (bus0.ack0_o && bus0.ack1_o)) excl_bad = 1;
            for (int j = 0; j < 2; j++) begin
               if (j == 0 ? bus0.ack0_o : bus0.ack1_o) begin
                  n_checks++;
                  if (!pending[j] || exp_q.size() == 0) begin
                     n_fail++; $display("FAIL rand_unexpected_ack: got ack%0d required none (round %0d)", j, r);
                  end else begin
                     e = exp_q.pop_front();
                     if ({1'(j), bus0.rdata_o} !== e) begin
                        n_fail++; $display("FAIL rand_ack: got owner=%0d rdata=%h required owner=%0d rdata=%h (round %0d)",
                           j, bus0.rdata_o, e[32], e[31:0], r);
                     end
                  end
                  pending[j] = 1'b0;
                  drop_req(1'(j));
               end
            end
         end
         if (pending != 2'b00) begin
            n_checks++; n_fail++;
            $display("FAIL rand_timeout: got pending=%b required 00 (round %0d)", pending, r);
            drop_req(1'b0); drop_req(1'b1);
         end
      end
      n_checks++;
      if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_leftover: got %0d queued required 0", exp_q.size()); end
      n_checks++;
      if (excl_bad !== 1'b0) begin n_fail++; $display("FAIL rand_exclusive: got overlap required none"); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_lat1();
      int re_cyc; int ack_k; logic [31:0] rd; bit got; bit stall_bad;
      re_cyc = 0; ack_k = -1; rd = '0; got = 0; stall_bad = 0;
      @(negedge clk);
      bus1.req0_i = 1'b1; bus1.wr0_i = 1'b0; bus1.adr0_i = 32'h08;
      for (int k = 1; k <= 10 && !got; k++) begin
         @(negedge clk);
         if (bus1.mem_re_o) re_cyc++;
         if (bus1.ack0_o) begin got = 1; ack_k = k; rd = bus1.rdata_o; end
         if (bus1.stall_o !== !got) stall_bad = 1;
      end
      bus1.req0_i = 1'b0;
      n_checks++;
      if (re_cyc !== LAT1) begin n_fail++; $display("FAIL lat1_re_cycles: got %0d required %0d", re_cyc, LAT1); end
      n_checks++;
      if (ack_k !== LAT1 + 1) begin n_fail++; $display("FAIL lat1_ack_cycle: got %0d required %0d", ack_k, LAT1 + 1); end
      n_checks++;
      if (rd !== init_word(2)) begin n_fail++; $display("FAIL lat1_rdata: got %h required %h", rd, init_word(2)); end
      n_checks++;
      if (stall_bad !== 1'b0) begin n_fail++; $display("FAIL lat1_stall: stall differed from req0 & ~ack0"); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      idle_inputs();
      last_rdata  = '0;
      last_served = 1'b1;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      test_reset();
      test_single_read();
      test_write_read();
      test_drop_mid_access();
      test_simultaneous();
      test_reset_mid_access();
      test_random();
      test_lat1();
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion required completion within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: Mem_Arbiter

Interface
REQ-001 Parameter LAT, default 2: data-memory access length in clock cycles, legal range 1..15.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 req0_i / req1_i  input  1 each  access request from requester 0 (pipeline MEM stage) / requester 1 (loader/debug port).
REQ-005 wr0_i / wr1_i  input  1 each  1 = write, 0 = read.
REQ-006 adr0_i / adr1_i  input  32 each  byte address.
REQ-007 data0_i / data1_i  input  32 each  write data.
REQ-008 gnt0_o / gnt1_o  output  1 each  requester currently owns the memory.
REQ-009 ack0_o / ack1_o  output  1 each  one-cycle completion pulse.
REQ-010 rdata_o  output  32  read data; valid while the matching ack is high.
REQ-011 stall_o  output  1  equals req0_i AND NOT ack0_o; freezes the pipeline.
REQ-012 mem_adr_o, mem_data_o  output  32 each  address and write data to the data memory.
REQ-013 mem_wr_o, mem_re_o  output  1 each  memory write and read strobes.
REQ-014 mem_data_i  input  32  memory read data.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-016 IDLE: with any request pending, the block SHALL select a winner per REQ-020, latch its wr/adr/data, set gntN_o, load cnt=LAT-1, and go to ACCESS next cycle.
REQ-017 ACCESS: mem_adr_o and mem_data_o SHALL carry the latched values; mem_wr_o or mem_re_o SHALL be high (by latched wr); cnt SHALL decrement each cycle.
REQ-018 ACCESS exit: at cnt==0 a read SHALL capture mem_data_i into rdata_o, a write SHALL leave rdata_o unchanged, and the FSM SHALL go to DONE; the strobes are high exactly LAT cycles.
REQ-019 DONE: ackN_o of the owner SHALL be high for exactly one cycle, gntN_o SHALL clear, and the FSM SHALL return to IDLE; request-to-ack latency is LAT+1 cycles from grant.
REQ-020 Arbitration (round-robin):
- If both requests are high in IDLE, the requester not granted last SHALL win.
- If one request is high, that requester SHALL win.
REQ-021 Request changes during ACCESS/DONE SHALL be ignored; a dropped request SHALL still complete and ack.
REQ-022 Requester inputs SHALL be sampled only in IDLE; a request held through its ack SHALL be treated as a new request.
REQ-023 Outside ACCESS, mem_wr_o and mem_re_o SHALL be 0; mem_adr_o and mem_data_o SHALL hold their last values.
REQ-024 At most one gnt SHALL be high at any time, and at most one ack SHALL be high at any time.
REQ-025 A back-to-back request SHALL have at least one IDLE cycle between DONE and the next ACCESS.

Reset
REQ-026 rst_i high SHALL immediately force:
- state = IDLE and cnt = 0;
- all gnt, ack, strobe, rdata_o, mem_adr_o and mem_data_o outputs = 0;
- last-grant = requester 1, so requester 0 wins the first tie.
REQ-027 Reset during ACCESS SHALL abort the access with no ack; memory contents are undefined for an aborted write.

Configuration
REQ-028 When macro MEM_ARB_FIXED_PRIO_EN is defined, requester 0 SHALL always win simultaneous requests and the last-grant register SHALL be omitted.
REQ-029 When MEM_ARB_FIXED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-020.

Verification
REQ-030 Single read: LAT=2, memory word 0x10 = 0xDEADBEEF, req0 read adr 0x10.
- mem_re_o high 2 cycles.
- ack0_o pulses at cycle 3 after grant with rdata_o = 0xDEADBEEF.
- stall_o is high until the ack.
REQ-031 Write then read: req1 writes 0x12345678 to 0x04, then reads 0x04.
- mem_wr_o high LAT cycles on the write.
- The read returns 0x12345678 on ack1_o.
REQ-032 Simultaneous requests (round-robin build): req0 and req1 held high continuously.
- Grants out of reset alternate 0, 1, 0, 1.
- With MEM_ARB_FIXED_PRIO_EN defined, only requester 0 is served.
REQ-033 Drop mid-access: req0 deasserted during ACCESS -> the access completes and ack0_o still pulses once.
REQ-034 Reset mid-access: rst_i asserted during the second ACCESS cycle.
- All outputs 0 immediately.
- No ack issued.
- The next tie goes to requester 0.
REQ-035 LAT=1: read 0x08 -> mem_re_o high 1 cycle and ack0_o 2 cycles after grant.
